bcd_counter_multi: RTL and testbench
====================================

Name: bcd_counter_multi

Overview:
Parametrised multi-digit BCD counter. Successor to the single-digit BCD counter.
Adds:
- N cascaded decimal digits
- up/down counting
- synchronous parallel load with digit validation
- a terminal-count carry/borrow output

Used wherever decimal display or timekeeping counts are needed. The carry output is cascadable into a further instance.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits; legal range 1..8.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
enable  input  1  count enable; 1 = advance one step per clock.
up_down  input  1  direction; 1 = count up, 0 = count down.
load  input  1  synchronous parallel load strobe.
load_value  input  4*NUM_DIGITS  packed BCD load value; digit 0 in bits [3:0].
count  output  4*NUM_DIGITS  packed BCD count; digit 0 in bits [3:0].
carry  output  1  terminal-count flag (carry when counting up, borrow when counting down).
load_error  output  1  registered flag: the last load contained an invalid digit.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low (rst_n). All state updates occur on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - count = 0, load_error = 0.
  - Reset overrides load and enable.
- Priority per edge: reset > load > enable > hold.
- Load (load=1, rst_n=1):
  - count takes load_value on the same edge; enable is ignored that cycle.
  - Any digit > 9 is loaded as 0. Valid digits in the same word load normally.
  - load_error is set to 1 if any digit was > 9, otherwise 0. It keeps its value until the next load or reset.
- Count, up (enable=1, up_down=1):
  - digit 0 increments every edge, 9 -> 0.
  - digit i (i>0) increments only when digits 0..i-1 are all 9.
  - 99..9 wraps to 00..0.
- Count, down (enable=1, up_down=0):
  - digit 0 decrements every edge, 0 -> 9.
  - digit i (i>0) decrements only when digits 0..i-1 are all 0.
  - 00..0 wraps to 99..9.
- Hold (enable=0, load=0): count unchanged.
- carry is combinational:
  - carry = rst_n & enable & ~load & (up_down ? all digits == 9 : all digits == 0).
  - It is high during the cycle before the wrap edge, so it can act as the enable of a cascaded instance.
- A change of up_down takes effect at the next edge. It is legal on any cycle, including at a terminal value; carry re-evaluates immediately.
- Digits never hold a value above 9, with no exceptions.
- Latency:
  - load and count steps: 1 edge to count.
  - carry: 0 cycles after its inputs change.
  - load_error: 1 edge.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W = 4.
  - BCD_MAX = 4'd9.
  - function bcd_valid(digit), returning digit <= 9.
- One sub-module, bcd_digit, one per digit:
  - inputs: clk, rst_n, load, load_digit, step_en, up_down.
  - outputs: digit, at_max, at_min.
  - Instantiated NUM_DIGITS times with a generate loop.
- The top level holds:
  - the ripple terminal-detect chain (AND of lower at_max/at_min)
  - the load_error register
  - the carry output

Test Plan:
1. Reset: hold rst_n=0 with enable=1 and load=1 (load_value=16'h1234) for 3 edges -> count=16'h0000, load_error=0, carry=0.
2. Up count and cascade (NUM_DIGITS=4): load 16'h0998, up_down=1, enable=1.
   - After 1 edge: count=16'h0999.
   - After the next edge: count=16'h1000.
   - Load 16'h9999 -> carry=1 while enabled; the next edge gives count=16'h0000, carry=0.
3. Down count and borrow: after reset, up_down=0, enable=1.
   - carry=1 at count=0000.
   - The next edge gives 16'h9999.
   - 10 further edges give 16'h9989.
4. Load validation: load 16'h12A4.
   - count=16'h1204, load_error=1.
   - Then load 16'h0042 -> load_error=0.
5. Priority and hold:
   - load=1 with enable=1 and load_value=16'h0500 -> count=16'h0500; no count step that cycle.
   - enable=0 for 5 edges -> count stays 16'h0500.
   - Assert rst_n=0 mid-count -> count=0 on that edge.
6. Direction flip at terminal: count=16'h9999, enable=1, up_down=1 gives carry=1.
   - Set up_down=0 in the same cycle -> carry=0 immediately.
   - The next edge gives 16'h9998.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit and a digit
// validity helper used by the counter and its digit slices.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    function automatic logic bcd_valid(input logic [BCD_DIGIT_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_counter_multi_if.sv
// Control/data bundle of the multi-digit BCD counter. The master drives
// the controls and load word; the slave (the counter) returns its state.
interface bcd_counter_multi_if #(
    parameter int NUM_DIGITS = 4
) ();
    import bcd_pkg::*;

    logic                              enable;
    logic                              up_down;
    logic                              load;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] load_value;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] count;
    logic                              carry;
    logic                              load_error;

    modport master (
        output enable, up_down, load, load_value,
        input  count, carry, load_error
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output count, carry, load_error
    );

endinterface : bcd_counter_multi_if

// File: rtl/bcd_digit.sv
// One decimal digit slice: synchronous reset, validated parallel load and
// a single up/down step when the neighbouring digits allow it.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [BCD_DIGIT_W-1:0] load_digit,
    input  logic                   step_en,
    input  logic                   up_down,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   at_max,
    output logic                   at_min
);

    logic [BCD_DIGIT_W-1:0] r_digit;
    logic [BCD_DIGIT_W-1:0] w_load_digit;

    // An out-of-range load digit becomes 0 so the register never leaves 0..9.
    assign w_load_digit = bcd_valid(load_digit) ? load_digit : '0;

    // NOTE: state registers use non-blocking assignments so every digit
    // samples the pre-edge value of its neighbours' terminal flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= w_load_digit;
        end else if (step_en) begin
            if (up_down) begin
                r_digit <= (r_digit >= BCD_MAX) ? '0 : r_digit + 4'd1;
            end else begin
                r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - 4'd1;
            end
        end
    end

    assign digit  = r_digit;
    assign at_max = (r_digit == BCD_MAX);
    assign at_min = (r_digit == '0);

endmodule : bcd_digit

// File: rtl/bcd_counter_multi.sv
// N-digit cascaded BCD up/down counter with validated load, load-error flag
// and a combinational terminal-count output usable as a cascade enable.
module bcd_counter_multi
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_counter_multi_if.slave  bus
);

    logic [NUM_DIGITS-1:0]             w_at_max;
    logic [NUM_DIGITS-1:0]             w_at_min;
    logic [NUM_DIGITS:0]               w_max_chain;
    logic [NUM_DIGITS:0]               w_min_chain;
    logic [NUM_DIGITS-1:0]             w_step_en;
    logic [NUM_DIGITS-1:0]             w_digit_bad;
    logic [BCD_DIGIT_W*NUM_DIGITS-1:0] w_count;
    logic                              r_load_error;

    // Chain bit i is set when every digit below i sits at its terminal value.
    assign w_max_chain[0] = 1'b1;
    assign w_min_chain[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign w_max_chain[i+1] = w_max_chain[i] & w_at_max[i];
        assign w_min_chain[i+1] = w_min_chain[i] & w_at_min[i];
        assign w_step_en[i]     = bus.enable & ~bus.load &
                                  (bus.up_down ? w_max_chain[i] : w_min_chain[i]);
        assign w_digit_bad[i]   =
            ~bcd_valid(bus.load_value[i*BCD_DIGIT_W +: BCD_DIGIT_W]);

        bcd_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (bus.load),
            .load_digit (bus.load_value[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .step_en    (w_step_en[i]),
            .up_down    (bus.up_down),
            .digit      (w_count[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .at_max     (w_at_max[i]),
            .at_min     (w_at_min[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_error <= 1'b0;
        end else if (bus.load) begin
            r_load_error <= |w_digit_bad;
        end
    end

    assign bus.count      = w_count;
    assign bus.load_error = r_load_error;
    assign bus.carry      = rst_n & bus.enable & ~bus.load &
                            (bus.up_down ? w_max_chain[NUM_DIGITS]
                                         : w_min_chain[NUM_DIGITS]);

endmodule : bcd_counter_multi

// File: tb/tb_bcd_counter_multi.sv
// Bench for bcd_counter_multi: an integer-valued reference model checked
// every cycle, plus directed literal expectations from the test plan.
module tb_bcd_counter_multi;

    localparam int N    = 4;
    localparam int W    = 4 * N;
    localparam int MAXV = 9999;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    bcd_counter_multi_if #(.NUM_DIGITS(N)) bus ();

    bcd_counter_multi #(.NUM_DIGITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the count is held as a plain integer.
    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int load_to_int(input logic [W-1:0] lv);
        logic [W-1:0] t;
        int           acc;
        int           wgt;
        int           d;
        t   = lv;
        acc = 0;
        wgt = 1;
        for (int i = 0; i < N; i++) begin
            d = int'(t[i*4 +: 4]);
            if (d < 10) acc += d * wgt;
            wgt *= 10;
        end
        return acc;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] lv);
        logic [W-1:0] t;
        logic         bad;
        t   = lv;
        bad = 1'b0;
        for (int i = 0; i < N; i++) if (t[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    int   m_val;
    logic m_err;
    bit   m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_val   <= 0;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
        end else if (bus.load) begin
            m_val <= load_to_int(bus.load_value);
            m_err <= has_bad(bus.load_value);
        end else if (bus.enable) begin
            if (bus.up_down) m_val <= (m_val == MAXV) ? 0 : m_val + 1;
            else             m_val <= (m_val == 0) ? MAXV : m_val - 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", 32'(bus.count), 32'(to_bcd(m_val)));
            check("model_load_error", 32'(bus.load_error), 32'(m_err));
            check("model_carry", 32'(bus.carry),
                  32'(rst_n && bus.enable && !bus.load &&
                      (bus.up_down ? (m_val == MAXV) : (m_val == 0))));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.enable     = 1'b1;
        bus.up_down    = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 16'h1234;

        // Reset dominates load and enable
        repeat (3) step();
        check("reset_count", 32'(bus.count), 32'h0000);
        check("reset_load_error", 32'(bus.load_error), 32'h0);
        check("reset_carry", 32'(bus.carry), 32'h0);

        // Up count and cascade
        rst_n          = 1'b1;
        bus.load_value = 16'h0998;
        step();
        check("load_0998", 32'(bus.count), 32'h0998);
        bus.load = 1'b0;
        step();
        check("up_0999", 32'(bus.count), 32'h0999);
        step();
        check("up_1000", 32'(bus.count), 32'h1000);
        bus.load       = 1'b1;
        bus.load_value = 16'h9999;
        step();
        bus.load = 1'b0;
        #1;
        check("carry_at_9999", 32'(bus.carry), 32'h1);
        step();
        check("wrap_up_0000", 32'(bus.count), 32'h0000);
        check("carry_after_wrap", 32'(bus.carry), 32'h0);

        // Down count and borrow
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        bus.up_down = 1'b0;
        #1;
        check("borrow_at_0000", 32'(bus.carry), 32'h1);
        step();
        check("wrap_down_9999", 32'(bus.count), 32'h9999);
        repeat (10) step();
        check("down_9989", 32'(bus.count), 32'h9989);

        // Load validation
        bus.enable     = 1'b0;
        bus.load       = 1'b1;
        bus.load_value = 16'h12A4;
        step();
        check("load_12A4_count", 32'(bus.count), 32'h1204);
        check("load_12A4_err", 32'(bus.load_error), 32'h1);
        bus.load_value = 16'h0042;
        step();
        check("load_0042_count", 32'(bus.count), 32'h0042);
        check("load_0042_err", 32'(bus.load_error), 32'h0);
        bus.load_value = 16'hFBC9;
        step();
        check("load_FBC9_count", 32'(bus.count), 32'h0009);
        check("load_FBC9_err", 32'(bus.load_error), 32'h1);
        bus.load = 1'b0;
        step();
        check("load_err_sticky", 32'(bus.load_error), 32'h1);

        // Priority and hold
        bus.load       = 1'b1;
        bus.enable     = 1'b1;
        bus.up_down    = 1'b1;
        bus.load_value = 16'h0500;
        step();
        check("load_over_enable", 32'(bus.count), 32'h0500);
        bus.load   = 1'b0;
        bus.enable = 1'b0;
        repeat (5) step();
        check("hold_0500", 32'(bus.count), 32'h0500);
        bus.enable = 1'b1;
        step();
        check("up_0501", 32'(bus.count), 32'h0501);
        rst_n = 1'b0;
        step();
        check("reset_mid_count", 32'(bus.count), 32'h0000);

        // Direction flip at terminal value
        rst_n          = 1'b1;
        bus.load       = 1'b1;
        bus.load_value = 16'h9999;
        step();
        bus.load    = 1'b0;
        bus.up_down = 1'b1;
        #1;
        check("flip_carry_up", 32'(bus.carry), 32'h1);
        bus.up_down = 1'b0;
        #1;
        check("flip_carry_down", 32'(bus.carry), 32'h0);
        step();
        check("flip_9998", 32'(bus.count), 32'h9998);

        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bcd_counter_multi
